// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes, data-memory
// wait freezes with timeout fault, and saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  input  logic        exmem_branch,
  input  logic        exmem_zflag,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_write,
  output logic        exmem_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_bubble,
  output logic        pc_src,
  output logic        mem_err,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       frozen;
  logic       taken;
  logic       load_use;

  always_comb begin
    frozen   = ((state == RUN) && mem_req && !mem_ready) ||
               ((state == MEM_WAIT) && !mem_ready);
    taken    = exmem_branch && exmem_zflag;
    load_use = idex_memread && (idex_rt != 5'd0) &&
               ((idex_rt == id_rs) || (idex_rt == id_rt));
  end

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b0;
    pc_src       = 1'b0;
    // While in reset the stage enables show their idle values regardless of inputs.
    if (rst_n) begin
      if ((state == HALT) || frozen) begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b1;
      end else if (taken) begin
        pc_src      = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req && !mem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == 8'(TIMEOUT)) begin
            state   <= HALT;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase

      if (!pc_write && (state != HALT) && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (pc_src && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, idex_rt;
  logic        idex_memread, exmem_branch, exmem_zflag, mem_req, mem_ready;
  logic        pc_write, ifid_write, idex_write, exmem_write;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_bubble, pc_src, mem_err;
  logic [15:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .exmem_branch(exmem_branch), .exmem_zflag(exmem_zflag),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_bubble(memwb_bubble), .pc_src(pc_src),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic [4:0] rs, rt, ldrt;
    logic       memread, branch, zflag, req, ready;
  } in_t;

  // Bit order: pc_write ifid_write idex_write exmem_write ifid_flush idex_flush exmem_flush memwb_bubble pc_src
  typedef logic [8:0] outs_t;
  localparam outs_t O_DEF    = 9'b1111_000_0_0;
  localparam outs_t O_FREEZE = 9'b0000_000_1_0;
  localparam outs_t O_BRANCH = 9'b1111_111_0_1;
  localparam outs_t O_LDUSE  = 9'b0011_010_0_0;

  typedef struct {
    string name;
    in_t   stim;
    outs_t exp;
    int    dstall;
    int    dflush;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: counts consecutive frozen cycles rather than tracking FSM states.
  int m_waited;
  bit m_halted;
  bit m_err;
  int m_stall;
  int m_flush;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic outs_t model_outs(input in_t i);
    bit frozen;
    frozen = !i.ready && (i.req || (m_waited > 0));
    if (m_halted || frozen) return O_FREEZE;
    if (i.branch && i.zflag) return O_BRANCH;
    if (i.memread && i.ldrt != 0 && (i.ldrt == i.rs || i.ldrt == i.rt)) return O_LDUSE;
    return O_DEF;
  endfunction

  function automatic outs_t dut_outs();
    return {pc_write, ifid_write, idex_write, exmem_write,
            ifid_flush, idex_flush, exmem_flush, memwb_bubble, pc_src};
  endfunction

  task automatic apply(input in_t i);
    id_rs = i.rs; id_rt = i.rt; idex_rt = i.ldrt; idex_memread = i.memread;
    exmem_branch = i.branch; exmem_zflag = i.zflag; mem_req = i.req; mem_ready = i.ready;
  endtask

  task automatic model_reset();
    m_waited = 0; m_halted = 0; m_err = 0; m_stall = 0; m_flush = 0;
  endtask

  // Entered and left at posedge+1: drive, check combinational outputs, clock, check registers.
  task automatic step(input in_t i, input string tag);
    outs_t e;
    bit    frozen;
    apply(i);
    #2;
    e = model_outs(i);
    check({tag, " outs"}, 32'(dut_outs()), 32'(e));
    frozen = !m_halted && !i.ready && (i.req || (m_waited > 0));
    @(posedge clk);
    if (!m_halted && !e[8] && m_stall < 65535) m_stall++;
    if (e[0] && m_flush < 65535) m_flush++;
    if (!m_halted) begin
      if (frozen) begin
        m_waited++;
        if (m_waited > TIMEOUT) begin m_halted = 1; m_err = 1; end
      end else begin
        m_waited = 0;
      end
    end
    #1;
    check({tag, " stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    check({tag, " flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
    check({tag, " mem_err"}, 32'(mem_err), 32'(m_err));
  endtask

  function automatic in_t mk(input logic [4:0] rs, rt, ldrt, input logic memread, branch, zflag, req, ready);
    in_t r;
    r.rs = rs; r.rt = rt; r.ldrt = ldrt; r.memread = memread;
    r.branch = branch; r.zflag = zflag; r.req = req; r.ready = ready;
    return r;
  endfunction

  // Asserts reset mid-cycle with a branch pending and checks the asynchronous clear.
  task automatic do_reset(input string tag);
    apply(mk(5'd5, 5'd5, 5'd5, 1, 1, 1, 1, 0));
    rst_n = 1'b0;
    #2;
    check({tag, " rst stall_cnt"}, 32'(stall_cnt), 32'd0);
    check({tag, " rst flush_cnt"}, 32'(flush_cnt), 32'd0);
    check({tag, " rst mem_err"}, 32'(mem_err), 32'd0);
    check({tag, " rst outs"}, 32'(dut_outs()), 32'(O_DEF));
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t vecs[$];

  initial begin
    int ps, pf;
    in_t r;

    vecs.push_back('{"idle",           mk(1, 2, 3, 0, 0, 0, 0, 0), O_DEF,    0, 0});
    vecs.push_back('{"lduse_rs",       mk(5, 7, 5, 1, 0, 0, 0, 0), O_LDUSE,  1, 0});
    vecs.push_back('{"lduse_rt",       mk(9, 6, 6, 1, 0, 0, 0, 1), O_LDUSE,  1, 0});
    vecs.push_back('{"zero_reg",       mk(0, 0, 0, 1, 0, 0, 0, 0), O_DEF,    0, 0});
    vecs.push_back('{"no_memread",     mk(4, 4, 4, 0, 0, 0, 0, 0), O_DEF,    0, 0});
    vecs.push_back('{"branch_taken",   mk(1, 2, 3, 0, 1, 1, 0, 0), O_BRANCH, 0, 1});
    vecs.push_back('{"branch_nottkn",  mk(1, 2, 3, 0, 1, 0, 0, 0), O_DEF,    0, 0});
    vecs.push_back('{"branch_lduse",   mk(5, 1, 5, 1, 1, 1, 0, 0), O_BRANCH, 0, 1});
    vecs.push_back('{"memreq_ready",   mk(3, 3, 3, 1, 0, 0, 1, 1), O_LDUSE,  1, 0});
    vecs.push_back('{"lduse_31",       mk(2, 31, 31, 1, 0, 0, 0, 0), O_LDUSE, 1, 0});

    rst_n = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
    model_reset();
    #2;
    check("reset outs", 32'(dut_outs()), 32'(O_DEF));
    check("reset mem_err", 32'(mem_err), 32'd0);
    check("reset stall_cnt", 32'(stall_cnt), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed vector table, each from the RUN state.
    foreach (vecs[k]) begin
      ps = int'(stall_cnt); pf = int'(flush_cnt);
      apply(vecs[k].stim);
      #2;
      check({vecs[k].name, " table outs"}, 32'(dut_outs()), 32'(vecs[k].exp));
      step(vecs[k].stim, vecs[k].name);
      check({vecs[k].name, " stall delta"}, 32'(int'(stall_cnt) - ps), 32'(vecs[k].dstall));
      check({vecs[k].name, " flush delta"}, 32'(int'(flush_cnt) - pf), 32'(vecs[k].dflush));
    end

    // Three-cycle memory wait with a taken branch held; branch acts once on release.
    ps = int'(stall_cnt); pf = int'(flush_cnt);
    for (int c = 0; c < 3; c++) begin
      step(mk(1, 2, 3, 0, 1, 1, 1, 0), "memwait");
      check("memwait frozen", 32'(pc_write), 32'd0);
    end
    apply(mk(1, 2, 3, 0, 1, 1, 1, 1));
    #2;
    check("memwait release outs", 32'(dut_outs()), 32'(O_BRANCH));
    step(mk(1, 2, 3, 0, 1, 1, 1, 1), "memwait_release");
    step(mk(1, 2, 3, 0, 0, 0, 0, 0), "memwait_run");
    check("memwait back in RUN", 32'(dut_outs()), 32'(O_DEF));
    check("memwait stall +3", 32'(int'(stall_cnt) - ps), 32'd3);
    check("memwait flush +1", 32'(int'(flush_cnt) - pf), 32'd1);

    // Timeout: 16 frozen cycles, then HALT with sticky mem_err.
    for (int c = 0; c < TIMEOUT + 1; c++) begin
      step(mk(0, 0, 0, 0, 0, 0, 1, 0), "timeout");
      check("timeout mem_err", 32'(mem_err), (c == TIMEOUT) ? 32'd1 : 32'd0);
    end
    ps = int'(stall_cnt);
    for (int c = 0; c < 4; c++) step(mk(5, 5, 5, 1, 1, 1, 0, 1), "halt");
    check("halt outs", 32'(dut_outs()), 32'(O_FREEZE));
    check("halt mem_err sticky", 32'(mem_err), 32'd1);
    check("halt stall frozen", 32'(stall_cnt), 32'(ps));
    do_reset("halt");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0), "after_halt");

    // Reset in the middle of a wait: the next cycle must be RUN (not frozen without mem_req).
    for (int c = 0; c < 3; c++) step(mk(0, 0, 0, 0, 0, 0, 1, 0), "midwait");
    do_reset("midwait");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    check("midwait RUN after reset", 32'(dut_outs()), 32'(O_DEF));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0), "midwait_run");

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      r.rs      = 5'($urandom_range(0, 3));
      r.rt      = 5'($urandom_range(0, 3));
      r.ldrt    = 5'($urandom_range(0, 3));
      r.memread = ($urandom_range(0, 1) == 1);
      r.branch  = ($urandom_range(0, 9) < 3);
      r.zflag   = ($urandom_range(0, 1) == 1);
      r.req     = ($urandom_range(0, 9) < 3);
      r.ready   = ($urandom_range(0, 9) < ((n / 500) % 2 == 0 ? 7 : 2));
      step(r, "random");
      if (m_halted && $urandom_range(0, 3) == 0) do_reset("random");
    end

    // Saturation of stall_cnt with a held load-use hazard.
    do_reset("sat");
    apply(mk(5, 0, 5, 1, 0, 0, 0, 0));
    repeat (65534) @(posedge clk);
    #1;
    check("sat stall 0xFFFE", 32'(stall_cnt), 32'hFFFE);
    repeat (6) @(posedge clk);
    #1;
    check("sat stall holds 0xFFFF", 32'(stall_cnt), 32'hFFFF);
    check("sat flush untouched", 32'(flush_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 15, max MEM_WAIT cycles before fault (range 1..255).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: id_rs, id_rt  in  5 each  source registers of the instruction in IF/ID.
REQ-005 Port: idex_memread  in  1  load in ID/EX; idex_rt  in  5  its destination.
REQ-006 Port: exmem_branch, exmem_zflag  in  1 each  branch and zero flag from EX/MEM.
REQ-007 Port: mem_req  in  1  EX/MEM holds a load or store; mem_ready  in  1  data memory done this cycle.
REQ-008 Port: pc_write, ifid_write, idex_write, exmem_write  out  1 each  register enables.
REQ-009 Port: ifid_flush, idex_flush, exmem_flush, memwb_bubble  out  1 each  zero control fields of the stage.
REQ-010 Port: pc_src  out  1  select branch target for PC.
REQ-011 Port: mem_err  out  1  sticky memory timeout fault.
REQ-012 Port: stall_cnt, flush_cnt  out  16 each  saturating performance counters.

Function
REQ-013 FSM states: RUN, MEM_WAIT, HALT; state, wait counter (8 bit), mem_err and counters are registered; all other outputs are combinational from state and inputs.
REQ-014 Default outputs (no event): all *_write=1, all flush/bubble=0, pc_src=0.
REQ-015 Priority per cycle: HALT > memory freeze > taken branch > load-use.
REQ-016 Memory freeze: (RUN and mem_req and !mem_ready) or (MEM_WAIT and !mem_ready) -> all *_write=0, memwb_bubble=1, pc_src=0, no flush.
REQ-017 RUN with mem_req=1 and mem_ready=0 -> next state MEM_WAIT, wait counter loads 1.
REQ-018 MEM_WAIT with mem_ready=1 -> freeze released that same cycle, default/branch/load-use rules apply, next state RUN, wait counter cleared.
REQ-019 MEM_WAIT with mem_ready=0 and wait counter == TIMEOUT -> next state HALT, mem_err set to 1; otherwise wait counter increments.
REQ-020 Taken branch: not frozen and exmem_branch=1 and exmem_zflag=1 -> pc_src=1, ifid_flush=1, idex_flush=1, exmem_flush=1, all *_write=1.
REQ-021 Load-use: not frozen, no taken branch, idex_memread=1, idex_rt!=0, and idex_rt==id_rs or idex_rt==id_rt -> pc_write=0, ifid_write=0, idex_flush=1; single cycle, no state change.
REQ-022 idex_rt==0 never triggers load-use.
REQ-023 HALT: all *_write=0, memwb_bubble=1, pc_src=0, flushes 0; exits only on reset.
REQ-024 stall_cnt increments each cycle with pc_write=0 in RUN or MEM_WAIT; not in HALT; saturates at 0xFFFF.
REQ-025 flush_cnt increments each cycle with pc_src=1; saturates at 0xFFFF.
REQ-026 Branch inputs held during freeze are evaluated on the release cycle, exactly once.

Reset
REQ-027 rst_n=0 asynchronously forces state RUN, wait counter 0, mem_err 0, stall_cnt 0, flush_cnt 0, independent of clk.
REQ-028 While rst_n=0 outputs show defaults (all *_write=1, flushes 0, pc_src=0, memwb_bubble=0).
REQ-029 Reset asserted mid-MEM_WAIT or in HALT aborts wait; first cycle after release is RUN.

Verification
REQ-030 Load-use: idex_memread=1, idex_rt=5, id_rs=5 for one cycle -> pc_write=0, ifid_write=0, idex_flush=1 that cycle; stall_cnt 0->1.
REQ-031 Zero register: idex_memread=1, idex_rt=0, id_rs=0 -> default outputs, stall_cnt unchanged.
REQ-032 Branch + load-use same cycle: exmem_branch=1, zflag=1, load-use hazard true -> pc_src=1, three flushes, pc_write=1; flush_cnt +1, stall_cnt unchanged.
REQ-033 Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> 3 frozen cycles, release on 4th, state back to RUN; stall_cnt +3.
REQ-034 Timeout (TIMEOUT=15): mem_req=1, mem_ready never -> HALT after 16 frozen cycles, mem_err=1, stays set; rst_n pulse low clears it and counters.
REQ-035 Saturation: force 65,536+ stall cycles -> stall_cnt holds 0xFFFF.
